// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential sign-magnitude multiplier.
package mul_pkg;

    localparam int unsigned DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/mul_seq_cnt.sv
// Step counter for mul_seq: synchronous clear, enable, terminal count at N-2.
module mul_cnt
    import mul_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] k,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            k <= '0;
        end else if (en) begin
            k <= k + W'(1);
        end
    end

    assign tc = (k == W'(N - 2));

endmodule

// File: rtl/mul_seq.sv
// Sequential sign-magnitude multiplier driving an external shift register for a.
// Optional overflow detection is built when MUL_SEQ_OVF_EN is defined.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] rb_q,
    output logic [N-1:0] rb_data,
    output logic         rb_load,
    output logic         rb_en,
    output logic [N-1:0] res,
    output logic         done,
    output logic         busy,
    output logic         ovf
);

    localparam int unsigned KW = (N > 2) ? $clog2(N - 1) : 1;

    state_t         state;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-2:0]   acc_q;
    logic [N-2:0]   acc_nxt;
    logic           sign_nxt;
    logic [KW-1:0]  k;
    logic           tc;
    logic           unused_rb_sign;

    assign unused_rb_sign = rb_q[N-1];
    assign rb_data        = a_q;

    mul_cnt #(
        .N (N),
        .W (KW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == IDLE) || (state == DONE)),
        .en    (state == STEP),
        .k     (k),
        .tc    (tc)
    );

    // rb_q carries a << k with high bits already dropped, so this sum wraps mod 2^(N-1).
    always_comb begin
        acc_nxt  = acc_q;
        if (b_q[k]) begin
            acc_nxt = acc_q + rb_q[N-2:0];
        end
        sign_nxt = (a_q[N-1] ^ b_q[N-1]) & (|acc_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            rb_load <= 1'b0;
            rb_en   <= 1'b0;
        end else begin
            done    <= 1'b0;
            rb_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        state   <= LOAD;
                        busy    <= 1'b1;
                        rb_en   <= 1'b1;
                        rb_load <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= STEP;
                end
                STEP: begin
                    acc_q <= acc_nxt;
                    if (tc) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        rb_en <= 1'b0;
                        done  <= 1'b1;
                        res   <= {sign_nxt, acc_nxt};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_SEQ_OVF_EN
    logic [2*N-3:0] shadow_q;
    logic [2*N-3:0] shadow_nxt;
    logic [2*N-3:0] a_ext;

    // Full-width product tracked alongside acc; any bit at or above N-1 is overflow.
    always_comb begin
        a_ext      = (2*N-2)'(a_q[N-2:0]);
        shadow_nxt = shadow_q;
        if (b_q[k]) begin
            shadow_nxt = shadow_q + (a_ext << k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            ovf      <= 1'b0;
        end else if ((state == IDLE) && start) begin
            shadow_q <= '0;
            ovf      <= 1'b0;
        end else if (state == STEP) begin
            shadow_q <= shadow_nxt;
            if (tc) begin
                ovf <= |shadow_nxt[2*N-3:N-1];
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
